// File: rtl/mem_access_if.sv
// Asynchronous RAM handshake bus between the access initiator and data memory.
interface mem_access_if;
    logic [31:0] address;
    logic [31:0] dataOut;
    logic        rw;
    logic        memEnable;
    logic        MOC;
    logic [31:0] memData;

    modport master (output address, dataOut, rw, memEnable, input MOC, memData);
    modport slave  (input address, dataOut, rw, memEnable, output MOC, memData);
endinterface

// File: rtl/mem_access_initiator.sv
// Turns single-cycle CPU load/store requests into memEnable/MOC handshakes on a
// big-endian 32-bit memory; sub-word stores are done as read-modify-write.
module mem_access_initiator #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic         req_rw,
    input  logic [1:0]   req_size,
    input  logic         req_signed,
    input  logic [31:0]  req_addr,
    input  logic [31:0]  req_wdata,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [31:0]  rdata,
    mem_access_if.master mem
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RD_EN, RD_WAIT, MERGE, WR_EN, WR_WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic          moc_meta_q, moc_s_q;
    logic          hold_q, hold_d;
    logic [1:0]    flush_q, flush_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    off_q, off_d;
    logic [1:0]    size_q, size_d;
    logic          signed_q, signed_d;
    logic          rmw_q, rmw_d;
    logic          eflag_q, eflag_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   word_q, word_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   dout_q, dout_d;
    logic          rw_q, rw_d;
    logic          men_q, men_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          bad_req, timeout;

    // Lane k of a big-endian word sits 8*(3-k) bits above bit 0.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] sz, input logic sgn);
        logic [31:0] sh;
        logic [31:0] r;
        r = w;
        case (sz)
            2'b00: begin
                sh = w >> {~off, 3'b000};
                r  = {{24{sgn & sh[7]}}, sh[7:0]};
            end
            2'b01: begin
                sh = w >> {~off[1], 4'b0000};
                r  = {{16{sgn & sh[15]}}, sh[15:0]};
            end
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                          input logic [1:0] off, input logic [1:0] sz);
        logic [31:0] m;
        logic [31:0] r;
        r = d;
        case (sz)
            2'b00: begin
                m = 32'h0000_00FF << {~off, 3'b000};
                r = (w & ~m) | (({24'h0, d[7:0]} << {~off, 3'b000}) & m);
            end
            2'b01: begin
                m = 32'h0000_FFFF << {~off[1], 4'b0000};
                r = (w & ~m) | (({16'h0, d[15:0]} << {~off[1], 4'b0000}) & m);
            end
            default: r = d;
        endcase
        return r;
    endfunction

    assign bad_req = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign timeout = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        off_d    = off_q;
        size_d   = size_q;
        signed_d = signed_q;
        rmw_d    = rmw_q;
        eflag_d  = eflag_q;
        wdata_d  = wdata_q;
        word_d   = word_q;
        rdata_d  = rdata_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        rw_d     = rw_q;
        // After reset the responder may still be mid-cycle: wait for the
        // synchronizer to refill and then for MOC to read idle.
        flush_d  = (flush_q != 2'd0) ? flush_q - 2'd1 : flush_q;
        hold_d   = hold_q & ~((flush_q == 2'd0) & moc_s_q);

        case (state_q)
            IDLE: if (req && !hold_q && moc_s_q) begin
                off_d    = req_addr[1:0];
                size_d   = req_size;
                signed_d = req_signed;
                wdata_d  = req_wdata;
                eflag_d  = bad_req;
                rmw_d    = 1'b0;
                if (bad_req) begin
                    state_d = DONE;
                end else begin
                    addr_d = {req_addr[31:2], 2'b00};
                    if (!req_rw) begin
                        state_d = RD_EN;
                    end else if (req_size == 2'b10) begin
                        dout_d  = req_wdata;
                        state_d = WR_EN;
                    end else begin
                        rmw_d   = 1'b1;
                        state_d = RD_EN;
                    end
                end
            end
            RD_EN: begin
                if (!moc_s_q) state_d = RD_WAIT;
                else if (timeout) begin eflag_d = 1'b1; state_d = DONE; end
            end
            RD_WAIT: begin
                if (moc_s_q) begin
                    word_d = mem.memData;
                    if (rmw_q) begin
                        state_d = MERGE;
                    end else begin
                        rdata_d = extract(mem.memData, off_q, size_q, signed_q);
                        state_d = DONE;
                    end
                end else if (timeout) begin
                    eflag_d = 1'b1;
                    state_d = DONE;
                end
            end
            MERGE: begin
                dout_d  = merge(word_q, wdata_q, off_q, size_q);
                state_d = WR_EN;
            end
            WR_EN: begin
                if (!moc_s_q) state_d = WR_WAIT;
                else if (timeout) begin eflag_d = 1'b1; state_d = DONE; end
            end
            WR_WAIT: begin
                if (moc_s_q) state_d = DONE;
                else if (timeout) begin eflag_d = 1'b1; state_d = DONE; end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == RD_EN) rw_d = 1'b0;
        if (state_d == WR_EN) rw_d = 1'b1;
        cnt_d  = (state_d != state_q) ? '0 : cnt_q + CW'(1);
        men_d  = (state_d == RD_EN) || (state_d == WR_EN);
        busy_d = (state_d != IDLE) || hold_d;
        done_d = (state_d == DONE);
        err_d  = (state_d == DONE) && eflag_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            moc_meta_q <= 1'b1;
            moc_s_q    <= 1'b1;
            hold_q     <= 1'b1;
            flush_q    <= 2'd2;
            cnt_q      <= '0;
            off_q      <= '0;
            size_q     <= '0;
            signed_q   <= 1'b0;
            rmw_q      <= 1'b0;
            eflag_q    <= 1'b0;
            wdata_q    <= '0;
            word_q     <= '0;
            rdata_q    <= '0;
            addr_q     <= '0;
            dout_q     <= '0;
            rw_q       <= 1'b0;
            men_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            moc_meta_q <= mem.MOC;
            moc_s_q    <= moc_meta_q;
            hold_q     <= hold_d;
            flush_q    <= flush_d;
            cnt_q      <= cnt_d;
            off_q      <= off_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            rmw_q      <= rmw_d;
            eflag_q    <= eflag_d;
            wdata_q    <= wdata_d;
            word_q     <= word_d;
            rdata_q    <= rdata_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            rw_q       <= rw_d;
            men_q      <= men_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign rdata         = rdata_q;
    assign mem.address   = addr_q;
    assign mem.dataOut   = dout_q;
    assign mem.rw        = rw_q;
    assign mem.memEnable = men_q;
endmodule

// File: tb/tb_mem_access_initiator.sv
// Random load/store traffic against a byte-addressed reference memory, with a
// scoreboard monitor checking every done pulse and the bus phases behind it.
module tb_mem_access_initiator;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0, req_rw = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        busy, done, err;
    logic [31:0] rdata;

    logic        moc_mem = 1'b1, moc_low = 1'b0, mem_stuck = 1'b0;
    logic [31:0] mem_rd = '0;
    logic [31:0] mem [0:255];
    logic [7:0]  ref_mem [0:1023];
    logic [31:0] model_rdata = '0;
    int          total = 0, bad = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          pulses;
        logic [1:0]  rwseq;
        logic [31:0] addr;
        logic        has_wr;
        logic [31:0] wword;
        int          len;
    } sb_t;
    sb_t sb_q[$];

    mem_access_if bus();
    assign bus.MOC     = moc_mem & ~moc_low;
    assign bus.memData = mem_rd;

    mem_access_initiator #(.TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata), .mem(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: memory is a plain byte array, most significant byte at the lowest address.
    task automatic model_req(input logic rw, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd, input bit stuck,
                             output sb_t e);
        int nbytes, v, base;
        e.err = 1'b0; e.rdata = model_rdata; e.pulses = 0; e.rwseq = 2'b00;
        e.addr = a & 32'hFFFF_FFFC; e.has_wr = 1'b0; e.wword = '0; e.len = 0;
        nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        base = int'(a) & ~3;
        if (sz == 2'b11 || (int'(a) % nbytes) != 0) begin
            e.err = 1'b1;
        end else if (stuck) begin
            e.err = 1'b1; e.pulses = 1; e.len = 8;
        end else if (!rw) begin
            v = 0;
            for (int i = 0; i < nbytes; i++) v = v * 256 + int'(ref_mem[int'(a) + i]);
            if (sg && nbytes == 1 && v >= 128) v = v - 256;
            if (sg && nbytes == 2 && v >= 32768) v = v - 65536;
            model_rdata = 32'(v);
            e.rdata = model_rdata; e.pulses = 1;
        end else begin
            for (int i = 0; i < nbytes; i++)
                ref_mem[int'(a) + i] = 8'((wd >> (8 * (nbytes - 1 - i))) & 32'hFF);
            e.pulses = (nbytes == 4) ? 1 : 2;
            e.rwseq = 2'b01; e.has_wr = 1'b1;
            e.wword = {ref_mem[base], ref_mem[base + 1], ref_mem[base + 2], ref_mem[base + 3]};
        end
    endtask

    task automatic issue(input logic rw, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input bit stuck);
        sb_t e;
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("busy_before_req", {31'b0, busy}, 32'd0);
        model_req(rw, sz, sg, a, wd, stuck, e);
        sb_q.push_back(e);
        @(negedge clk);
        req = 1'b1; req_rw = rw; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        @(negedge clk);
        // Scramble request fields so a design that fails to register them is caught.
        req = 1'b0; req_rw = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        if (sb_q.size() != 0) begin
            chk("done_wait_expired", 32'd0, 32'd1);
            sb_q.delete();
        end
    endtask

    // Responder: drops MOC a little after the memEnable rise, completes, raises MOC.
    initial begin
        logic [7:0]  ma;
        logic        mw;
        logic [31:0] md;
        forever begin
            @(posedge bus.memEnable);
            if (!mem_stuck) begin
                ma = bus.address[9:2]; mw = bus.rw; md = bus.dataOut;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                @(negedge clk);
                moc_mem = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                if (mw) mem[ma] = md;
                else mem_rd = mem[ma];
                moc_mem = 1'b1;
            end
        end
    end

    // Monitor: tracks bus pulses and checks each done against the scoreboard.
    initial begin
        int          pulses, en_len;
        logic [1:0]  rwseq;
        logic        prev_en, addr_diff, busy_chk;
        logic [31:0] addr_cap, wr_cap;
        sb_t         e;
        pulses = 0; en_len = 0; rwseq = 0; prev_en = 0; addr_diff = 0; busy_chk = 0;
        addr_cap = 0; wr_cap = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pulses = 0; en_len = 0; rwseq = 0; prev_en = 0; addr_diff = 0; busy_chk = 0;
            end else begin
                if (busy_chk) chk("busy_after_done", {31'b0, busy}, 32'd0);
                busy_chk = 0;
                if (bus.memEnable && !prev_en) begin
                    pulses++;
                    rwseq = {rwseq[0], bus.rw};
                    en_len = 0;
                    if (pulses == 1) addr_cap = bus.address;
                    else if (bus.address !== addr_cap) addr_diff = 1'b1;
                    if (bus.rw) wr_cap = bus.dataOut;
                end
                if (bus.memEnable) en_len++;
                prev_en = bus.memEnable;
                if (err) chk("err_only_with_done", {31'b0, done}, 32'd1);
                if (done) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("err", {31'b0, err}, {31'b0, e.err});
                        chk("rdata", rdata, e.rdata);
                        chk("mem_pulses", 32'(pulses), 32'(e.pulses));
                        if (e.pulses > 0) begin
                            chk("rw_phases", {30'b0, rwseq}, {30'b0, e.rwseq});
                            chk("address", addr_cap, e.addr);
                            chk("address_stable", {31'b0, addr_diff}, 32'd0);
                        end
                        if (e.has_wr) chk("write_data", wr_cap, e.wword);
                        if (e.len != 0) chk("en_high_cycles", 32'(en_len), 32'(e.len));
                    end
                    pulses = 0; rwseq = 0; addr_diff = 0; busy_chk = 1'b1;
                end
            end
        end
    end

    initial begin
        logic [31:0] w, a;
        logic [1:0]  sz;
        int          r, n;
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            mem[i] = w;
            for (int b = 0; b < 4; b++) ref_mem[4 * i + b] = w[31 - 8 * b -: 8];
        end
        mem[4] = 32'h8899_AABB;
        ref_mem[16] = 8'h88; ref_mem[17] = 8'h99; ref_mem[18] = 8'hAA; ref_mem[19] = 8'hBB;

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_address", bus.address, 32'd0);
        chk("rst_dataOut", bus.dataOut, 32'd0);
        chk("rst_rw", {31'b0, bus.rw}, 32'd0);
        chk("rst_memEnable", {31'b0, bus.memEnable}, 32'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0);
        issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0);
        issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0);
        issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h1234_5677, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b0);
        issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(1'b1, 2'b01, 1'b0, 32'h21, 32'hFFFF_0000, 1'b0);

        mem_stuck = 1'b1;
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1);
        mem_stuck = 1'b0;

        for (int t = 0; t < 150; t++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            a  = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 2) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            issue(1'($urandom), sz, 1'($urandom), a, $urandom, 1'b0);
        end

        // Reset while the responder holds MOC low, then a request during the hold window.
        @(negedge clk);
        req = 1'b1; req_rw = 1'b0; req_size = 2'b10; req_addr = 32'h10;
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (!bus.memEnable && n < 20) begin @(negedge clk); n++; end
        chk("abort_en_seen", {31'b0, bus.memEnable}, 32'd1);
        moc_low = 1'b1; reset = 1'b1;
        @(negedge clk);
        chk("rst_edge_memEnable", {31'b0, bus.memEnable}, 32'd0);
        reset = 1'b0;
        model_rdata = '0;
        repeat (4) @(negedge clk);
        req = 1'b1; req_rw = 1'b0; req_size = 2'b10; req_addr = 32'h20;
        @(negedge clk);
        req = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("hold_busy", {31'b0, busy}, 32'd1);
            chk("hold_memEnable", {31'b0, bus.memEnable}, 32'd0);
        end
        chk("hold_rdata", rdata, 32'd0);
        moc_low = 1'b0;
        n = 0;
        while (busy && n < 20) begin @(negedge clk); n++; end
        chk("hold_release", {31'b0, busy}, 32'd0);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0);

        for (int i = 0; i < 256; i++)
            chk("final_mem", mem[i], {ref_mem[4 * i], ref_mem[4 * i + 1], ref_mem[4 * i + 2], ref_mem[4 * i + 3]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
